// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg: shared queue-entry layout, redirect-source encoding and reset PC
package if_fetch_queue_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } fq_entry_t;
    localparam int FQ_W = $bits(fq_entry_t);
    typedef enum logic [1:0] {RD_NONE, RD_BR, RD_ERTN, RD_EX} redir_src_t;
    function automatic redir_src_t redir_src(input logic wb_ex, input logic ertn, input logic br);
        return wb_ex ? RD_EX : ertn ? RD_ERTN : br ? RD_BR : RD_NONE;
    endfunction
endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, first-word-fall-through head
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             empty, full, do_push, do_pop;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop & ~empty;
    // a full FIFO may still accept a write when its head leaves the same cycle
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch with decoupling queue, outstanding-request tracking and redirect discard
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          QDEPTH   = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_inst,
    output logic [31:0] fs_pc,
    output logic        fs_adef_ex,
    input  logic        br_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        wb_ex,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_entry,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] fetch_vaddr,
    input  logic [31:0] fetch_paddr
);
    localparam int CW = $clog2(QDEPTH) + 1;
    logic [31:0]             fetch_pc, target, pc_head;
    logic [CW-1:0]           outstanding, discard_cnt, q_cnt;
    logic [$clog2(MAX_OUT):0] pc_cnt;
    logic                    adef_block, redirect, aligned, q_full, q_empty;
    logic                    hs, dok, live, adef_push, q_push, q_pop;
    redir_src_t              src;
    fq_entry_t               adef_ent, data_ent, q_din, q_dout;
    assign src      = redir_src(wb_ex, ertn_flush, br_taken);
    assign redirect = src != RD_NONE;
    assign target   = src == RD_EX ? ex_entry : src == RD_ERTN ? ertn_entry : br_target;
    assign aligned  = fetch_pc[1:0] == 2'b00;
    assign q_full   = q_cnt == CW'(QDEPTH);
    assign q_empty  = q_cnt == '0;
    // reserve a queue slot for every request in flight so responses always fit
    assign inst_sram_req = resetn & ~redirect & ~adef_block & aligned & ~br_stall
                         & (outstanding < CW'(MAX_OUT))
                         & (({1'b0, outstanding} + {1'b0, q_cnt}) < (CW + 1)'(QDEPTH));
    assign hs   = inst_sram_req & inst_sram_addr_ok;
    // with nothing outstanding a response is a leftover from before reset
    assign dok  = inst_sram_data_ok & (outstanding != '0);
    assign live = dok & (discard_cnt == '0);
    assign adef_push = resetn & ~redirect & ~aligned & ~adef_block & ~q_full;
    assign adef_ent  = '{pc: fetch_pc, inst: 32'h0, adef: 1'b1};
    assign data_ent  = '{pc: pc_head, inst: inst_sram_rdata, adef: 1'b0};
    assign q_din     = adef_push ? adef_ent : data_ent;
    assign q_push    = adef_push | live;
    assign fs_to_ds_valid = resetn & ~q_empty & ~redirect;
    assign q_pop     = fs_to_ds_valid & ds_allowin;
    assign fs_pc      = fs_to_ds_valid ? q_dout.pc : 32'h0;
    assign fs_inst    = fs_to_ds_valid ? q_dout.inst : 32'h0;
    assign fs_adef_ex = fs_to_ds_valid & q_dout.adef;
    assign fetch_vaddr    = fetch_pc;
    assign inst_sram_addr = fetch_paddr;
    fetch_fifo #(.WIDTH(FQ_W), .DEPTH(QDEPTH)) u_queue (
        .clk(clk), .resetn(resetn), .flush(redirect), .push(q_push), .pop(q_pop),
        .din(q_din), .dout(q_dout), .count(q_cnt)
    );
    fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_pc_fifo (
        .clk(clk), .resetn(resetn), .flush(redirect), .push(hs), .pop(live),
        .din(fetch_pc), .dout(pc_head), .count(pc_cnt)
    );
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            adef_block  <= 1'b0;
        end else begin
            fetch_pc    <= redirect ? target : hs ? fetch_pc + 32'd4 : fetch_pc;
            outstanding <= outstanding + CW'(hs) - CW'(dok);
            // after a redirect every response still pending belongs to the old path
            discard_cnt <= redirect ? outstanding - CW'(dok) : discard_cnt - CW'(dok & (discard_cnt != '0));
            adef_block  <= redirect ? 1'b0 : adef_block | adef_push;
        end
    end
    assert property (@(posedge clk) disable iff (!resetn)
        (live & ~redirect) |-> ((~q_full | q_pop) & (pc_cnt != '0)));
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: scoreboard bench with a latency-configurable inst_sram model
module tb_if_fetch_queue;
    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam logic [31:0] XLAT   = 32'h40000000;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } exp_t;
    typedef struct { logic [31:0] rdata; int ready; } pend_t;
    logic clk = 0, resetn = 0, ds_allowin = 1, br_stall = 0, br_taken = 0, wb_ex = 0, ertn_flush = 0;
    logic [31:0] br_target = 0, ex_entry = 0, ertn_entry = 0;
    logic inst_sram_addr_ok = 1, inst_sram_data_ok = 0;
    logic [31:0] inst_sram_rdata = 0;
    logic fs_to_ds_valid, fs_adef_ex, inst_sram_req;
    logic [31:0] fs_inst, fs_pc, inst_sram_addr, fetch_vaddr, fetch_paddr;
    int checks = 0, failures = 0, cyc = 0, lat = 1, adef_reqs = 0;
    logic adef_mode = 0;
    logic [31:0] model_pc = RST_PC;
    exp_t exp_q[$];
    pend_t pend[$];
    logic [31:0] pop_pcs[$];
    int pop_cycs[$];

    always #5 clk = ~clk;
    assign fetch_paddr = fetch_vaddr ^ XLAT;

    if_fetch_queue dut (
        .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid),
        .fs_inst(fs_inst), .fs_pc(fs_pc), .fs_adef_ex(fs_adef_ex), .br_stall(br_stall),
        .br_taken(br_taken), .br_target(br_target), .wb_ex(wb_ex), .ex_entry(ex_entry),
        .ertn_flush(ertn_flush), .ertn_entry(ertn_entry), .inst_sram_req(inst_sram_req),
        .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .fetch_vaddr(fetch_vaddr), .fetch_paddr(fetch_paddr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'ha5a50f0f;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock: called at a falling edge with the stimulus inputs already set
    task automatic step();
        exp_t e;
        logic [31:0] tgt;
        inst_sram_data_ok = pend.size() > 0 && pend[0].ready <= cyc;
        inst_sram_rdata   = inst_sram_data_ok ? pend[0].rdata : 32'h0;
        #1;
        tgt = wb_ex ? ex_entry : ertn_flush ? ertn_entry : br_target;
        if (!resetn) begin
            exp_q.delete();
            model_pc  = RST_PC;
            adef_mode = 0;
            foreach (pend[i]) pend[i].rdata = 32'hdeadbeef;
        end else if (wb_ex || ertn_flush || br_taken) begin
            check("redir_req", inst_sram_req, 0);
            check("redir_vld", fs_to_ds_valid, 0);
            exp_q.delete();
            model_pc  = tgt;
            adef_mode = tgt[1:0] != 2'b00;
            if (adef_mode) exp_q.push_back('{pc: tgt, inst: 32'h0, adef: 1'b1});
        end else begin
            if (fs_to_ds_valid && ds_allowin) begin
                if (exp_q.size() == 0) check("unexp_pop", fs_pc, 32'hffffffff);
                else begin
                    e = exp_q.pop_front();
                    check("pop_pc", fs_pc, e.pc);
                    check("pop_inst", fs_inst, e.inst);
                    check("pop_adef", {31'h0, fs_adef_ex}, {31'h0, e.adef});
                end
                pop_pcs.push_back(fs_pc);
                pop_cycs.push_back(cyc);
            end
            if (adef_mode && inst_sram_req) adef_reqs++;
            if (inst_sram_req && inst_sram_addr_ok) begin
                check("req_addr", inst_sram_addr, model_pc ^ XLAT);
                pend.push_back('{rdata: mem_word(model_pc), ready: cyc + lat});
                exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc), adef: 1'b0});
                model_pc += 4;
            end
        end
        if (inst_sram_data_ok) void'(pend.pop_front());
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_pops(input int n, input int budget);
        for (int i = 0; i < budget && pop_pcs.size() < n; i++) step();
        check("wait_pops", pop_pcs.size(), n);
    endtask

    task automatic clear_log();
        pop_pcs.delete();
        pop_cycs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        repeat (3) step();
        pend.delete();
        check("rst_vld", fs_to_ds_valid, 0);
        check("rst_req", inst_sram_req, 0);
        check("rst_adef", fs_adef_ex, 0);
        check("rst_inst", fs_inst, 0);
        check("rst_pc", fs_pc, 0);
        check("rst_vaddr", fetch_vaddr, RST_PC);
        // streaming after reset with single-cycle sram
        clear_log();
        resetn = 1;
        wait_pops(3, 20);
        check("stream_pc0", pop_pcs[0], RST_PC);
        check("stream_pc1", pop_pcs[1], RST_PC + 4);
        check("stream_pc2", pop_pcs[2], RST_PC + 8);
        check("stream_gap1", 32'(pop_cycs[1] - pop_cycs[0]), 1);
        check("stream_gap2", 32'(pop_cycs[2] - pop_cycs[1]), 1);
        // decode stall fills the queue, then drains with nothing lost
        ds_allowin = 0;
        repeat (15) step();
        check("full_req", inst_sram_req, 0);
        check("full_cnt", exp_q.size(), 4);
        check("full_vld", fs_to_ds_valid, 1);
        ds_allowin = 1;
        clear_log();
        repeat (12) step();
        check("drain_pops", pop_pcs.size() >= 4, 1);
        // branch with two requests in flight
        lat = 3;
        for (int i = 0; i < 20 && pend.size() < 2; i++) step();
        check("two_out", pend.size(), 2);
        br_taken = 1; br_target = 32'h1c000100;
        step();
        br_taken = 0;
        clear_log();
        wait_pops(1, 30);
        check("br_pc", pop_pcs[0], 32'h1c000100);
        // redirect priority
        lat = 1;
        wb_ex = 1; br_taken = 1; ex_entry = 32'h1c008000; br_target = 32'h1c000200;
        step();
        wb_ex = 0; br_taken = 0;
        check("ex_prio", fetch_vaddr, 32'h1c008000);
        clear_log();
        wait_pops(1, 20);
        check("ex_pc", pop_pcs[0], 32'h1c008000);
        ertn_flush = 1; br_taken = 1; ertn_entry = 32'h1c00a000;
        step();
        ertn_flush = 0; br_taken = 0;
        check("ertn_prio", fetch_vaddr, 32'h1c00a000);
        // misaligned target produces a single adef entry and blocks fetch
        br_taken = 1; br_target = 32'h1c000102;
        step();
        br_taken = 0;
        clear_log();
        adef_reqs = 0;
        repeat (10) step();
        check("adef_noreq", adef_reqs, 0);
        check("adef_pops", pop_pcs.size(), 1);
        check("adef_pc", pop_pcs[0], 32'h1c000102);
        check("adef_hold", fetch_vaddr, 32'h1c000102);
        wb_ex = 1; ex_entry = 32'h1c008000;
        step();
        wb_ex = 0;
        clear_log();
        wait_pops(1, 20);
        check("adef_resume", pop_pcs[0], 32'h1c008000);
        // reset with a request in flight; its late response must be ignored
        resetn = 0;
        repeat (2) step();
        pend.delete();
        lat = 2;
        resetn = 1;
        step();
        check("rst_inflight", pend.size(), 1);
        resetn = 0;
        step();
        resetn = 1;
        clear_log();
        wait_pops(2, 20);
        check("post_rst_pc0", pop_pcs[0], RST_PC);
        check("post_rst_pc1", pop_pcs[1], RST_PC + 4);
        // random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            inst_sram_addr_ok = $urandom_range(0, 3) != 0;
            ds_allowin = $urandom_range(0, 3) != 0;
            br_stall = $urandom_range(0, 7) == 0;
            lat = int'($urandom_range(1, 4));
            if ($urandom_range(0, 29) == 0) begin
                br_taken = 1;
                br_target = 32'h1c001000 + 32'($urandom_range(0, 255)) * 4;
            end
            step();
            br_taken = 0;
        end
        inst_sram_addr_ok = 1; ds_allowin = 1; br_stall = 0;
        clear_log();
        wait_pops(4, 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
